// File: rtl/mem_access_ctrl.sv
// Pipeline-side initiator for mem_system: latches one read/write, holds the memory request
// until done, stalls the pipeline, absorbs flushes, and flags protocol errors and hangs.
module mem_access_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_rd,
  input  logic              pipe_wr,
  input  logic [DATA_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              pipe_flush,
  output logic              pipe_stall,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_rvalid,
  output logic              pipe_hit,
  output logic              pipe_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_dataout,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              mem_hit,
  input  logic              mem_err,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StBusy  = 3'd1,
    StDrain = 3'd2,
    StResp  = 3'd3,
    StErr   = 3'd4
  } state_e;

  // Last value the timeout counter may hold while still waiting for mem_done.
  localparam logic [7:0] ToLast = 8'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic              op_rd_q;
  logic              op_wr_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              hit_q;
  logic              resp_rd_q;
  logic [7:0]        to_cnt_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;

  logic req;
  logic req_ok;
  logic req_bad;
  logic can_accept;
  logic accept;
  logic in_access;
  logic timed_out;
  logic unused_mem_stall;

  // mem_stall is informational only; the handshake is driven purely by mem_done.
  assign unused_mem_stall = mem_stall;

  assign req        = pipe_rd | pipe_wr;
  assign req_ok     = req & ~pipe_flush & ~(pipe_rd & pipe_wr);
  assign req_bad    = pipe_rd & pipe_wr & ~pipe_flush;
  assign can_accept = (state_q == StIdle) | (state_q == StResp);
  assign accept     = can_accept & req_ok;
  assign in_access  = (state_q == StBusy) | (state_q == StDrain);
  assign timed_out  = in_access & ~mem_done & (to_cnt_q == ToLast);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (req_bad) begin
          state_d = StErr;
        end else if (req_ok) begin
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (mem_err) begin
          state_d = StErr;
        end else if (mem_done) begin
          state_d = StResp;
        end else if (timed_out) begin
          state_d = StErr;
        end else if (pipe_flush) begin
          // The cache is mid-sequence, so the access runs to completion and is discarded.
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mem_err) begin
          state_d = StErr;
        end else if (mem_done) begin
          state_d = StIdle;
        end else if (timed_out) begin
          state_d = StErr;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StErr;
      end
    endcase
  end

  // Request latch, response capture and timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      resp_rd_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      if (accept) begin
        op_rd_q  <= pipe_rd;
        op_wr_q  <= pipe_wr;
        addr_q   <= pipe_addr;
        wdata_q  <= pipe_wdata;
        to_cnt_q <= '0;
      end else if (in_access && to_cnt_q != 8'hFF) begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end
      if (state_q == StBusy && mem_done) begin
        hit_q     <= mem_hit;
        // A flush in the completion cycle still completes, but the read is not reported.
        resp_rd_q <= op_rd_q & ~pipe_flush;
        if (op_rd_q) begin
          rdata_q <= mem_dataout;
        end
      end
    end
  end

  // Saturating hit/miss statistics, counted for every completion including drained ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (in_access && mem_done) begin
      if (mem_hit) begin
        if (hit_cnt_q != '1) begin
          hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
      end else begin
        if (miss_cnt_q != '1) begin
          miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Output logic
  always_comb begin
    pipe_stall  = 1'b0;
    pipe_rvalid = 1'b0;
    pipe_hit    = 1'b0;
    pipe_err    = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    unique case (state_q)
      StIdle: begin
        pipe_stall = req & ~pipe_flush;
      end
      StBusy, StDrain: begin
        pipe_stall = 1'b1;
        mem_rd     = op_rd_q;
        mem_wr     = op_wr_q;
      end
      StResp: begin
        pipe_stall  = req & ~pipe_flush;
        pipe_rvalid = resp_rd_q;
        pipe_hit    = hit_q;
      end
      StErr: begin
        pipe_stall = 1'b1;
        pipe_err   = 1'b1;
      end
      default: begin
        pipe_stall = 1'b1;
      end
    endcase
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign pipe_rdata = rdata_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl, checked cycle by cycle against a
// transaction-level reference model of the access/response/error behaviour.
module tb_mem_access_ctrl;

  localparam int DW = 16;
  localparam int TO = 63;
  localparam int CW = 8;
  localparam int CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pipe_rd, pipe_wr, pipe_flush;
  logic [DW-1:0] pipe_addr, pipe_wdata;
  logic          pipe_stall, pipe_rvalid, pipe_hit, pipe_err;
  logic [DW-1:0] pipe_rdata;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_addr, mem_wdata, mem_dataout;
  logic          mem_done, mem_stall, mem_hit, mem_err;
  logic [CW-1:0] hit_cnt, miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_W (DW),
    .TIMEOUT(TO),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_rd    (pipe_rd),
    .pipe_wr    (pipe_wr),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_flush (pipe_flush),
    .pipe_stall (pipe_stall),
    .pipe_rdata (pipe_rdata),
    .pipe_rvalid(pipe_rvalid),
    .pipe_hit   (pipe_hit),
    .pipe_err   (pipe_err),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_dataout(mem_dataout),
    .mem_done   (mem_done),
    .mem_stall  (mem_stall),
    .mem_hit    (mem_hit),
    .mem_err    (mem_err),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  // Reference model: one outstanding access, optional one-cycle response, sticky error.
  bit          m_err, m_busy, m_drain, m_resp, m_resp_rd, m_op_rd, m_hit;
  logic [DW-1:0] m_addr, m_wdata, m_rdata;
  int          m_age, m_hits, m_misses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_busy = 0; m_drain = 0; m_resp = 0; m_resp_rd = 0; m_op_rd = 0; m_hit = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_age = 0; m_hits = 0; m_misses = 0;
  endtask

  function automatic int sat(input int n);
    return (n > CntMax) ? CntMax : n;
  endfunction

  task automatic check_outputs();
    bit outst;
    bit req;
    outst = m_busy || m_drain;
    req   = pipe_rd || pipe_wr;
    check_eq("stall", 32'(pipe_stall), 32'(m_err || outst || (req && !pipe_flush)));
    check_eq("rvalid", 32'(pipe_rvalid), 32'(m_resp && m_resp_rd));
    if (m_resp && m_resp_rd) check_eq("rdata", 32'(pipe_rdata), 32'(m_rdata));
    if (m_resp) check_eq("hit", 32'(pipe_hit), 32'(m_hit));
    check_eq("err", 32'(pipe_err), 32'(m_err));
    check_eq("mem_rd", 32'(mem_rd), 32'(outst && m_op_rd));
    check_eq("mem_wr", 32'(mem_wr), 32'(outst && !m_op_rd));
    if (outst) begin
      check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
      check_eq("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    check_eq("hit_cnt", 32'(hit_cnt), 32'(sat(m_hits)));
    check_eq("miss_cnt", 32'(miss_cnt), 32'(sat(m_misses)));
  endtask

  // Advance the model by one clock using the inputs held across that edge.
  task automatic model_step();
    if (m_err) return;
    if (m_busy || m_drain) begin
      m_age++;
      if (mem_done) begin
        if (mem_hit) m_hits++;
        else m_misses++;
      end
      if (mem_err) begin
        m_err = 1; m_busy = 0; m_drain = 0;
      end else if (mem_done) begin
        if (m_busy) begin
          m_resp    = 1;
          m_resp_rd = m_op_rd && !pipe_flush;
          m_hit     = mem_hit;
          if (m_op_rd) m_rdata = mem_dataout;
        end
        m_busy = 0; m_drain = 0;
      end else if (m_age >= TO) begin
        m_err = 1; m_busy = 0; m_drain = 0;
      end else if (m_busy && pipe_flush) begin
        m_busy = 0; m_drain = 1;
      end
    end else begin
      m_resp = 0;
      if ((pipe_rd || pipe_wr) && !pipe_flush) begin
        if (pipe_rd && pipe_wr) begin
          m_err = 1;
        end else begin
          m_busy = 1; m_op_rd = pipe_rd; m_addr = pipe_addr; m_wdata = pipe_wdata; m_age = 0;
        end
      end
    end
  endtask

  task automatic idle_in();
    pipe_rd = 0; pipe_wr = 0; pipe_flush = 0;
    pipe_addr = DW'($urandom); pipe_wdata = DW'($urandom);
    mem_done = 0; mem_hit = 0; mem_err = 0; mem_dataout = DW'($urandom);
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic tick();
    mem_stall = 1'($urandom);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 0;
    #1;
    check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_stall", 32'(pipe_stall), 32'd0);
    check_eq("rst_err", 32'(pipe_err), 32'd0);
    check_eq("rst_rvalid", 32'(pipe_rvalid), 32'd0);
    check_eq("rst_rdata", 32'(pipe_rdata), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check_eq("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    mem_stall = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Read hit
    idle_in(); pipe_rd = 1; pipe_addr = 16'h0010; tick();
    mem_done = 1; mem_hit = 1; mem_dataout = 16'hBEEF; tick();
    idle_in(); tick();
    check_eq("rh_hit_cnt", 32'(hit_cnt), 32'd1);
    check_eq("rh_rdata", 32'(pipe_rdata), 32'h0000BEEF);

    // Write miss, done after 12 cycles
    idle_in(); pipe_wr = 1; pipe_addr = 16'h2468; pipe_wdata = 16'h1357; tick();
    for (int i = 0; i < 12; i++) begin
      mem_done = (i == 11); mem_hit = 0; tick();
    end
    idle_in(); tick();
    check_eq("wm_miss_cnt", 32'(miss_cnt), 32'd1);

    // Flush three cycles into a read miss
    idle_in(); pipe_rd = 1; pipe_addr = 16'h0abc; tick();
    for (int i = 0; i < 10; i++) begin
      pipe_flush = (i == 2); mem_done = (i == 8); mem_hit = 0; tick();
    end
    idle_in(); tick();
    check_eq("fl_miss_cnt", 32'(miss_cnt), 32'd2);

    // Flush coincident with completion: read completes but is not reported
    idle_in(); pipe_rd = 1; tick();
    pipe_flush = 1; mem_done = 1; mem_hit = 1; tick();
    idle_in(); tick();

    // Back-to-back hits until the hit counter saturates
    do_reset();
    idle_in(); pipe_rd = 1;
    for (int i = 0; i < 2 * (CntMax + 10); i++) begin
      pipe_addr = DW'($urandom); mem_done = 1'(i % 2); mem_hit = 1;
      mem_dataout = DW'($urandom); tick();
    end
    idle_in(); tick();
    check_eq("sat_hit_cnt", 32'(hit_cnt), 32'(CntMax));

    // Randomized legal traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      idle_in();
      r = int'($urandom_range(0, 9));
      pipe_rd    = (r < 4);
      pipe_wr    = (r >= 4 && r < 6);
      pipe_flush = ($urandom_range(0, 9) == 0);
      if (pipe_flush && $urandom_range(0, 3) == 0) begin
        pipe_rd = 1; pipe_wr = 1;
      end
      mem_done = ($urandom_range(0, 2) == 0);
      mem_hit  = 1'($urandom);
      tick();
    end

    // Reset in the middle of an access drops the memory request at once
    idle_in(); pipe_rd = 1; tick();
    idle_in(); tick();
    check_eq("mid_mem_rd", 32'(mem_rd), 32'd1);
    do_reset();

    // Illegal simultaneous read and write
    idle_in(); pipe_rd = 1; pipe_wr = 1; tick();
    idle_in(); mem_done = 1; mem_hit = 1;
    repeat (4) tick();
    check_eq("ill_err", 32'(pipe_err), 32'd1);
    do_reset();

    // Memory error during an access
    idle_in(); pipe_wr = 1; tick();
    idle_in(); tick();
    mem_err = 1; tick();
    idle_in(); repeat (3) tick();
    check_eq("merr_err", 32'(pipe_err), 32'd1);
    do_reset();

    // Hung access times out
    idle_in(); pipe_rd = 1; pipe_addr = 16'h5555; tick();
    idle_in();
    for (int i = 0; i < TO + 4; i++) begin
      mem_done = (i >= TO); mem_hit = 1; tick();
    end
    check_eq("to_err", 32'(pipe_err), 32'd1);
    check_eq("to_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("to_stall", 32'(pipe_stall), 32'd1);
    check_eq("to_hit_cnt", 32'(hit_cnt), 32'd0);
    do_reset();
    idle_in(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
